preamble_insert: RTL and testbench
==================================

PREAMBLE_INSERT -- requirements
Module: preamble_insert

Interface
REQ-001 Parameter PRE_LEN, default 128, number of preamble sign codes held in ROM.
REQ-002 Parameter PRE_REP, default 2, number of times the ROM sequence is transmitted per frame.
REQ-003 Parameter AMP, default 16'sh2000, magnitude of each preamble component.
REQ-004 The block SHALL run on one clock; reset is synchronous and active-low.
REQ-005 CLK_I  in  1  sole clock, rising edge.
REQ-006 RST_I  in  1  synchronous active-low reset.
REQ-007 DAT_I  in  32  payload sample; [31:16] Im, [15:0] Re, two's complement.
REQ-008 STB_I / CYC_I  in  1 each  input sample valid / frame active.
REQ-009 ACK_O  out  1  input sample accepted this cycle.
REQ-010 DAT_O  out  32  output sample, same packing as DAT_I.
REQ-011 STB_O / CYC_O  out  1 each  output sample valid / output frame active.
REQ-012 ACK_I  in  1  downstream accepts DAT_O this cycle.

Function
REQ-013 Handshake: transfer occurs when STB and ACK are both high on a rising edge; DAT_O and STB_O SHALL hold stable while STB_O=1 and ACK_I=0.
REQ-014 FSM states IDLE, PRE, DATA, DONE; reset state IDLE.
REQ-015 IDLE->PRE when CYC_I=1; CYC_O SHALL rise on the same edge.
REQ-016 PRE emits PRE_LEN*PRE_REP samples; the ROM index wraps PRE_LEN-1->0 and the repeat counter increments on the wrap.
REQ-017 Sign code mapping: code bit0 = Re sign, bit1 = Im sign; 0 -> +AMP, 1 -> -AMP (e.g. code 2'b10 -> Re=+AMP, Im=-AMP).
REQ-018 ACK_O SHALL be 0 in IDLE, PRE and DONE.
REQ-019 PRE->DATA after the last preamble sample is accepted by ACK_I, if CYC_I=1.
REQ-020 PRE->DONE instead if CYC_I=0 at that point; the full preamble is always sent.
REQ-021 In DATA, ACK_O = STB_I & (~STB_O | ACK_I); an accepted DAT_I SHALL appear on DAT_O with STB_O=1 one cycle later, unmodified.
REQ-022 Back-to-back operation: sustained throughput SHALL be one sample per cycle when ACK_I is held high, in both PRE and DATA.
REQ-023 DATA->DONE when CYC_I=0 on an edge; no further input is accepted.
REQ-024 DONE: pending output drains; when STB_O=0, CYC_O->0 and FSM->IDLE.
REQ-025 CYC_I held high through DONE->IDLE SHALL start a new frame with a full preamble.
REQ-026 A simultaneous preamble-end and CYC_I fall SHALL take REQ-020.

Reset
REQ-027 RST_I=0 sampled on an edge SHALL force IDLE, STB_O=0, CYC_O=0, ACK_O=0, DAT_O=0, and clear the ROM index and repeat counter, regardless of current state.
REQ-028 Reset mid-frame SHALL discard the pending sample; the next frame restarts at ROM index 0.

Structure
REQ-029 A shared package SHALL hold: the FSM state encodings, the sign-code-to-sample mapping constants, and the AMP default.
REQ-030 The preamble sign table SHALL live in a sub-module preamble_rom: index in, 2-bit code out, combinational, PRE_LEN entries.
REQ-031 The sign-code convention SHALL match the receiver correlator taps bit for bit.

Verification
REQ-032 Frame, ACK_I=1, 5 data words: CYC_O rises; 256 preamble samples at 1/cycle, then 5 data words equal to DAT_I, then CYC_O falls.
REQ-033 ROM entry 0 = 2'b11 -> DAT_O = {16'shE000, 16'shE000}; entry 1 = 2'b00 -> {16'sh2000, 16'sh2000}.
REQ-034 ACK_I low for 3 cycles at preamble sample 130 -> DAT_O holds; sample 131 follows after ACK_I returns; total 256 preamble samples, no repeats or skips.
REQ-035 CYC_I falls at preamble sample 40 -> all 256 preamble samples sent, ACK_O stays 0, CYC_O falls after the last sample.
REQ-036 RST_I=0 during data word 3 -> next cycle all outputs 0; the next frame begins with ROM entry 0.
REQ-037 STB_I toggling 1,0,1 with ACK_I=1 in DATA -> STB_O pattern follows one cycle late; DAT_O values match in order.

Source files
------------

// File: rtl/preamble_insert_pkg.sv
// Shared definitions for the preamble inserter: FSM encoding, sign-code mapping and defaults.
package preamble_insert_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } state_e;

  // Default magnitude of each preamble component.
  localparam logic signed [15:0] AmpDefault = 16'sh2000;

  // Sign-code layout, shared with the receiver correlator taps.
  localparam int unsigned CodeReBit = 0;
  localparam int unsigned CodeImBit = 1;
  localparam logic        SignNeg   = 1'b1;

  // Map a 2-bit sign code onto a packed {Im, Re} sample of magnitude amp.
  function automatic logic [31:0] code_to_sample(input logic [1:0]         code,
                                                 input logic signed [15:0] amp);
    logic signed [15:0] re;
    logic signed [15:0] im;
    re = (code[CodeReBit] == SignNeg) ? -amp : amp;
    im = (code[CodeImBit] == SignNeg) ? -amp : amp;
    return {im, re};
  endfunction

endpackage

// File: rtl/preamble_rom.sv
// Preamble sign table: combinational lookup of the 2-bit sign code for a ROM index.
module preamble_rom import preamble_insert_pkg::*; #(
  parameter int unsigned PRE_LEN = 128
) (
  input  logic [((PRE_LEN > 1) ? $clog2(PRE_LEN) : 1)-1:0] idx_i,
  output logic [1:0]                                        code_o
);

  localparam int unsigned IdxW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

  // Each sign is the inverted parity of a fixed tap set of the index bits; entry 0 is all-negative.
  localparam logic [IdxW-1:0] MaskRe = IdxW'(32'h05);
  localparam logic [IdxW-1:0] MaskIm = IdxW'(32'h29);

  // Table lookup; indices at or beyond PRE_LEN are never addressed.
  always_comb begin
    code_o            = 2'b00;
    code_o[CodeReBit] = ~(^(idx_i & MaskRe));
    code_o[CodeImBit] = ~(^(idx_i & MaskIm));
  end

endmodule

// File: rtl/preamble_insert.sv
// Frame-level preamble inserter: prepends PRE_REP passes of the preamble ROM to each payload frame.
module preamble_insert import preamble_insert_pkg::*; #(
  parameter int unsigned        PRE_LEN = 128,
  parameter int unsigned        PRE_REP = 2,
  parameter logic signed [15:0] AMP     = AmpDefault
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I
);

  localparam int unsigned     IdxW    = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam int unsigned     RepW    = $clog2(PRE_REP + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(PRE_LEN - 1);
  localparam logic [RepW-1:0] RepAll  = RepW'(PRE_REP);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [RepW-1:0]   rep_q, rep_d;
  logic [31:0]       dat_q, dat_d;
  logic              stb_q, stb_d;
  logic              cyc_q, cyc_d;
  logic              ack;
  logic              slot_free;
  logic [1:0]        code;

  preamble_rom #(
    .PRE_LEN (PRE_LEN)
  ) u_rom (
    .idx_i  (idx_q),
    .code_o (code)
  );

  // Output register can take a new sample when empty or being drained this cycle.
  assign slot_free = ~stb_q | ACK_I;

  // Next-state, output register load and input acknowledge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    dat_d   = dat_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    ack     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CYC_I) begin
          state_d = StPre;
          cyc_d   = 1'b1;
          idx_d   = '0;
          rep_d   = '0;
        end
      end
      StPre: begin
        if (slot_free) begin
          if (rep_q == RepAll) begin
            // All preamble samples loaded; the last one leaves the slot on this edge.
            stb_d   = 1'b0;
            state_d = CYC_I ? StData : StDone;
          end else begin
            dat_d = code_to_sample(code, AMP);
            stb_d = 1'b1;
            if (idx_q == IdxLast) begin
              idx_d = '0;
              rep_d = rep_q + 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      StData: begin
        ack = CYC_I & STB_I & slot_free;
        if (!CYC_I) begin
          state_d = StDone;
          if (ACK_I) stb_d = 1'b0;
        end else if (slot_free) begin
          stb_d = STB_I;
          if (STB_I) dat_d = DAT_I;
        end
      end
      StDone: begin
        if (!stb_q) begin
          cyc_d   = 1'b0;
          state_d = StIdle;
        end else if (ACK_I) begin
          stb_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rep_q   <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
    end
  end

  assign ACK_O = ack;
  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign CYC_O = cyc_q;

endmodule

// File: tb/tb_preamble_insert.sv
// Randomised self-checking bench for preamble_insert against a frame-level reference model.
module tb_preamble_insert;

  localparam int TOT = 256;  // 128 ROM entries sent twice
  localparam int PLEN = 128;
  localparam logic [15:0] APOS = 16'h2000;
  localparam logic [15:0] ANEG = 16'hE000;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] DAT_I = '0;
  logic        STB_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic        ACK_I = 1'b0;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        STB_O;
  logic        CYC_O;

  int checks = 0;
  int failures = 0;

  // Monitor state, updated once per cycle by tick().
  int          cyc_n = 0;
  logic [31:0] out_q[$];
  int          out_t[$];
  int          acc_t[$];
  int          hold_err = 0;
  int          ackpre_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;
  logic        acc = 1'b0;
  logic        cyc_s = 1'b0;

  preamble_insert dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .DAT_I (DAT_I),
    .STB_I (STB_I),
    .CYC_I (CYC_I),
    .ACK_O (ACK_O),
    .DAT_O (DAT_O),
    .STB_O (STB_O),
    .CYC_O (CYC_O),
    .ACK_I (ACK_I)
  );

  initial forever #5 CLK_I = ~CLK_I;

  // Reference preamble: sign bit = 1 when the tapped index bits have even parity.
  function automatic logic [31:0] pre_sample(input int i);
    int j;
    logic [15:0] re;
    logic [15:0] im;
    j  = i % PLEN;
    re = (((j + (j / 4)) % 2) == 0) ? ANEG : APOS;
    im = (((j + (j / 8) + (j / 32)) % 2) == 0) ? ANEG : APOS;
    return {im, re};
  endfunction

  // Sample at the falling edge (inputs are stable there), then advance to just after the rising edge.
  task automatic tick();
    @(negedge CLK_I);
    acc = STB_I && ACK_O && RST_I;
    if (!RST_I) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!STB_O || DAT_O !== prev_dat)) hold_err++;
      prev_stall = STB_O && !ACK_I;
      prev_dat   = DAT_O;
      if (ACK_O && out_q.size() < TOT) ackpre_err++;
      if (STB_O && ACK_I) begin
        out_q.push_back(DAT_O);
        out_t.push_back(cyc_n);
      end
      if (acc) acc_t.push_back(cyc_n);
    end
    cyc_s = CYC_O;
    cyc_n++;
    @(posedge CLK_I);
    #1;
  endtask

  // Drive one frame and check the output stream against the model.
  // stb_mode: 0 always offer, 1 random, 2 offer on even cycles only.
  task automatic run_frame(input string nm, input int n, input int ack_pct, input int stb_mode,
                           input int drop_at, input int stall_at, input int rst_at,
                           input bit keep_cyc);
    logic [31:0] words[$];
    logic [31:0] expv;
    int w = 0, stall_left = 0, guard = 0, mism = 0, first_bad = -1, lat_err = 0, gap_err = 0;
    int exp_len;
    bit stalled = 0, dropped = 0, rose = 0, tmo = 0, did_rst = 0;
    out_q.delete();
    out_t.delete();
    acc_t.delete();
    hold_err   = 0;
    ackpre_err = 0;
    for (int i = 0; i < n; i++) words.push_back($urandom);
    CYC_I = 1'b1;
    while (1) begin
      if (rst_at >= 0 && out_q.size() >= rst_at) begin
        RST_I = 1'b0;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        ACK_I = 1'b0;
        tick();
        did_rst = 1;
        checks++;
        if (STB_O !== 1'b0) begin failures++; $display("FAIL %s rst_stb got %b want 0", nm, STB_O); end
        checks++;
        if (CYC_O !== 1'b0) begin failures++; $display("FAIL %s rst_cyc got %b want 0", nm, CYC_O); end
        checks++;
        if (ACK_O !== 1'b0) begin failures++; $display("FAIL %s rst_ack got %b want 0", nm, ACK_O); end
        checks++;
        if (DAT_O !== 32'h0) begin
          failures++;
          $display("FAIL %s rst_dat got %h want 00000000", nm, DAT_O);
        end
        RST_I = 1'b1;
        tick();
        break;
      end
      if (drop_at >= 0) begin
        if (out_q.size() >= drop_at) begin
          CYC_I   = 1'b0;
          dropped = 1;
        end
      end else if (w == n) begin
        if (!dropped) begin
          CYC_I   = 1'b0;
          dropped = 1;
        end else begin
          CYC_I = keep_cyc;
        end
      end
      case (stb_mode)
        0:       STB_I = (w < n) && CYC_I;
        1:       STB_I = (w < n) && CYC_I && ($urandom_range(0, 1) == 1);
        default: STB_I = (w < n) && CYC_I && (cyc_n % 2 == 0);
      endcase
      DAT_I = (w < n) ? words[w] : $urandom;
      if (stall_left > 0) begin
        ACK_I = 1'b0;
        stall_left--;
      end else if (stall_at >= 0 && !stalled && out_q.size() == stall_at && STB_O) begin
        stalled    = 1;
        stall_left = 2;
        ACK_I      = 1'b0;
      end else begin
        ACK_I = (int'($urandom_range(0, 99)) < ack_pct);
      end
      tick();
      if (guard == 1) rose = cyc_s;
      if (acc) w++;
      if (dropped && !cyc_s) break;
      guard++;
      if (guard > 4000) begin
        tmo = 1;
        break;
      end
    end
    STB_I = 1'b0;

    checks++;
    if (tmo) begin failures++; $display("FAIL %s timeout got %0d cycles want CYC_O fall", nm, guard); end
    checks++;
    if (!rose) begin failures++; $display("FAIL %s cyc_rise got %b want 1", nm, rose); end
    exp_len = did_rst ? rst_at : (TOT + ((drop_at >= 0) ? 0 : n));
    checks++;
    if (out_q.size() != exp_len) begin
      failures++;
      $display("FAIL %s out_count got %0d want %0d", nm, out_q.size(), exp_len);
    end
    for (int i = 0; i < out_q.size(); i++) begin
      expv = (i < TOT) ? pre_sample(i) : ((i - TOT < n) ? words[i - TOT] : 32'hxxxx_xxxx);
      if (out_q[i] !== expv) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL %s data got %0d bad samples (first idx %0d = %h, want %h) want 0", nm, mism,
               first_bad, out_q[first_bad],
               (first_bad < TOT) ? pre_sample(first_bad) : words[first_bad - TOT]);
    end
    checks++;
    if (hold_err != 0) begin failures++; $display("FAIL %s hold got %0d want 0", nm, hold_err); end
    checks++;
    if (ackpre_err != 0) begin
      failures++;
      $display("FAIL %s ack_in_preamble got %0d want 0", nm, ackpre_err);
    end
    if (!did_rst) begin
      checks++;
      if (acc_t.size() != ((drop_at >= 0) ? 0 : n)) begin
        failures++;
        $display("FAIL %s accepted got %0d want %0d", nm, acc_t.size(), (drop_at >= 0) ? 0 : n);
      end
    end
    if (ack_pct == 100 && !did_rst && out_t.size() == TOT + n && acc_t.size() == n
        && drop_at < 0) begin
      for (int k = 0; k < n; k++) if (out_t[TOT + k] != acc_t[k] + 1) lat_err++;
      checks++;
      if (lat_err != 0) begin failures++; $display("FAIL %s latency got %0d late want 0", nm, lat_err); end
      if (stall_at < 0) begin
        checks++;
        if (out_t[TOT - 1] - out_t[0] != TOT - 1) begin
          failures++;
          $display("FAIL %s pre_rate got %0d cycles want %0d", nm, out_t[TOT - 1] - out_t[0] + 1, TOT);
        end
      end
      for (int k = 1; k < n; k++)
        if (out_t[TOT + k] - out_t[TOT + k - 1] != ((stb_mode == 2) ? 2 : 1)) gap_err++;
      if (stb_mode != 1) begin
        checks++;
        if (gap_err != 0) begin failures++; $display("FAIL %s data_gap got %0d bad want 0", nm, gap_err); end
      end
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b0;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    ACK_I = 1'b1;
    DAT_I = $urandom;
    repeat (3) tick();
    checks++;
    if (STB_O !== 1'b0) begin failures++; $display("FAIL reset_stb got %b want 0", STB_O); end
    checks++;
    if (CYC_O !== 1'b0) begin failures++; $display("FAIL reset_cyc got %b want 0", CYC_O); end
    checks++;
    if (ACK_O !== 1'b0) begin failures++; $display("FAIL reset_ack got %b want 0", ACK_O); end
    checks++;
    if (DAT_O !== 32'h0) begin failures++; $display("FAIL reset_dat got %h want 00000000", DAT_O); end
    RST_I = 1'b1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    tick();
    tick();
    checks++;
    if (CYC_O !== 1'b0) begin failures++; $display("FAIL idle_cyc got %b want 0", CYC_O); end
  endtask

  task automatic test_basic();
    run_frame("basic", 5, 100, 0, -1, -1, -1, 0);
    checks++;
    if (out_q.size() < 2) begin
      failures++;
      $display("FAIL rom_entries got %0d samples want >=2", out_q.size());
    end else if (out_q[0] !== 32'hE000E000 || out_q[1] !== 32'h20002000) begin
      failures++;
      $display("FAIL rom_entries got %h %h want e000e000 20002000", out_q[0], out_q[1]);
    end
  endtask

  task automatic test_stall();
    run_frame("stall130", 6, 100, 0, -1, 130, -1, 0);
  endtask

  task automatic test_cyc_drop();
    run_frame("drop40", 0, 100, 0, 40, -1, -1, 0);
    run_frame("drop40_slow", 0, 70, 0, 40, -1, -1, 0);
  endtask

  task automatic test_reset_mid_frame();
    run_frame("rst_data3", 8, 100, 0, -1, -1, TOT + 2, 0);
    run_frame("after_rst_data", 4, 100, 0, -1, -1, -1, 0);
    run_frame("rst_pre50", 8, 100, 0, -1, -1, 50, 0);
    run_frame("after_rst_pre", 3, 100, 0, -1, -1, -1, 0);
  endtask

  task automatic test_stb_toggle();
    run_frame("stb_toggle", 6, 100, 2, -1, -1, -1, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++)
      run_frame("random", int'($urandom_range(1, 20)), int'($urandom_range(50, 95)), 1, -1, -1,
                -1, 0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 4, 100, 0, -1, -1, -1, 1);
    run_frame("b2b_second", 7, 80, 1, -1, -1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_cyc_drop();
    test_reset_mid_frame();
    test_stb_toggle();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
